// File: rtl/prog_delay_pkg.sv
// Purpose  : shared helpers for the programmable delay line (select width, select clamping).
// Latency  : n/a (package only).
// Backpres.: n/a; the delay line has no ready path, only a freeze enable.
//
// Contents:
//   DEF_WIDTH / DEF_MAX_DELAY : default build parameters
//   sel_width()  : width of a select that can encode 0..MAX_DELAY
//   clamp_sel()  : maps a requested delay onto the legal range 1..MAX_DELAY
// The {valid, data} stage struct depends on WIDTH, so it is declared inside
// the top module and handed to the tap mux as a type parameter.
package prog_delay_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_DELAY = 16;

    function automatic int sel_width(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // 0 means "as short as possible", anything past the deepest tap means
    // "as deep as possible".
    function automatic int clamp_sel(input int sel, input int max_delay);
        if (sel == 0) begin
            return 1;
        end else if (sel > max_delay) begin
            return max_delay;
        end else begin
            return sel;
        end
    endfunction

endpackage : prog_delay_pkg

// File: rtl/delay_tap_mux.sv
// Purpose  : MAX_DELAY:1 selection of one {valid, data} stage by the registered delay select.
// Latency  : combinational, 0 cycles.
// Backpres.: none; pure mux.
//
// Ports:
//   i_taps  : stage array, index 1 is the youngest word
//   i_sel   : registered delay (1..MAX_DELAY); any other code falls back to tap 1
//   o_stage : the selected stage
module delay_tap_mux #(
    parameter int  MAX_DELAY = 16,
    parameter int  SEL_W     = 5,
    parameter type stage_t   = logic [8:0]
) (
    input  stage_t           i_taps [1:MAX_DELAY],
    input  logic [SEL_W-1:0] i_sel,
    output stage_t           o_stage
);

    always_comb begin
        o_stage = i_taps[1];
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_stage = i_taps[k];
            end
        end
    end

endmodule : delay_tap_mux

// File: rtl/prog_delay_line.sv
// Purpose  : runtime-programmable, cycle-exact delay line for a WIDTH-bit bus with valid tracking.
// Latency  : sel_q enabled cycles (1..MAX_DELAY); valid_out masked for sel_q enabled cycles after a retune.
// Backpres.: no ready; i_en=0 freezes all state and holds the outputs.
//
// Optional feature macro: PROG_DELAY_SELERR_EN adds the sticky o_sel_err port.
//
// Ports:
//   i_clk        : clock, all state on the rising edge
//   i_rst        : synchronous active-high reset, dominates i_en
//   i_en         : advance enable
//   i_valid_in   : qualifier for i_data_in
//   i_data_in    : input word
//   i_delay_sel  : requested delay in enabled cycles (clamped to 1..MAX_DELAY)
//   o_valid_out  : qualifier for o_data_out
//   o_data_out   : delayed word
//   o_sel_err    : sticky out-of-range request flag (PROG_DELAY_SELERR_EN only)
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int MAX_DELAY = DEF_MAX_DELAY,
    localparam int SEL_W     = sel_width(MAX_DELAY)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid_in,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [SEL_W-1:0] i_delay_sel,
    output logic             o_valid_out,
    output logic [WIDTH-1:0] o_data_out
`ifdef PROG_DELAY_SELERR_EN
    ,
    output logic             o_sel_err
`endif
);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] dat;
    } stage_t;

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(MAX_DELAY);
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

    stage_t           r_tap [1:MAX_DELAY];
    logic [SEL_W-1:0] r_sel_q;
    logic [SEL_W-1:0] r_fill_cnt;

    logic [SEL_W-1:0] w_sel_clamped;
    logic             w_retune;
    stage_t           w_sel_stage;

    assign w_sel_clamped = SEL_W'(clamp_sel(int'(i_delay_sel), MAX_DELAY));
    assign w_retune      = (w_sel_clamped != r_sel_q);

    // Shift register, effective delay and refill counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 1; k <= MAX_DELAY; k++) begin
                r_tap[k] <= '0;
            end
            r_sel_q    <= SEL_ONE;
            r_fill_cnt <= '0;
        end else if (i_en) begin
            r_tap[1] <= '{vld: i_valid_in, dat: i_data_in};
            for (int k = 2; k <= MAX_DELAY; k++) begin
                r_tap[k] <= r_tap[k-1];
            end
            r_sel_q <= w_sel_clamped;
            // A retune restarts the refill count: words already in the line
            // were timed for the old delay and must not surface as valid.
            if (w_retune) begin
                r_fill_cnt <= '0;
            end else if (r_fill_cnt != SEL_MAX) begin
                r_fill_cnt <= r_fill_cnt + SEL_ONE;
            end
        end
    end

    delay_tap_mux #(
        .MAX_DELAY (MAX_DELAY),
        .SEL_W     (SEL_W),
        .stage_t   (stage_t)
    ) u_tap_mux (
        .i_taps  (r_tap),
        .i_sel   (r_sel_q),
        .o_stage (w_sel_stage)
    );

    // Outputs depend only on registers; no combinational path from i_data_in.
    assign o_data_out  = w_sel_stage.dat;
    assign o_valid_out = w_sel_stage.vld && (r_fill_cnt >= r_sel_q);

`ifdef PROG_DELAY_SELERR_EN
    logic r_sel_err;
    logic w_sel_oor;

    assign w_sel_oor = (i_delay_sel == '0) || (i_delay_sel > SEL_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel_err <= 1'b0;
        end else if (i_en && w_sel_oor) begin
            r_sel_err <= 1'b1;
        end
    end

    assign o_sel_err = r_sel_err;
`endif

endmodule : prog_delay_line
